// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and instruction-field positions
// for the multi-cycle control sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB,
        BRANCH,
        ERR
    } state_t;

    localparam int OPC_MSB  = 7;
    localparam int OPC_LSB  = 6;
    localparam int JUMP_BIT = 7;

endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: counts FETCH cycles without Imem_Ack.
// Ports: clk, rst_n, clear, enable in; expired out (comb, last allowed cycle).
module fetch_watchdog #(
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [W-1:0] LIM = W'(FETCH_TIMEOUT - 1);

    logic [W-1:0] cnt;

    // Fires on the FETCH_TIMEOUT-th waiting cycle so the FSM
    // leaves FETCH after exactly FETCH_TIMEOUT cycles.
    assign expired = enable && (cnt == LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/WB (or BRANCH) control FSM with IR,
// watchdog and retire counter. In: Clk Reset Start Stop Stall Imem_Ack Instr_In.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 16,
    parameter int CNT_W         = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Stall,
    input  logic             Imem_Ack,
    input  logic [7:0]       Instr_In,
    output logic             Imem_Req,
    output logic [7:0]       IR_Out,
    output logic             PC_En,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             ImmSel,
    output logic             Busy,
    output logic             Timeout_Err,
    output logic [CNT_W-1:0] Retired_Count
);

    state_t           state;
    logic [7:0]       ir;
    logic [CNT_W-1:0] retired;
    logic             err;
    logic             wd_expired;

    fetch_watchdog #(
        .FETCH_TIMEOUT(FETCH_TIMEOUT)
    ) u_wd (
        .clk    (Clk),
        .rst_n  (Reset),
        .clear  (state != FETCH),
        .enable ((state == FETCH) && !Imem_Ack),
        .expired(wd_expired)
    );

    // Strobes are gated by Stall so a frozen WB/BRANCH fires only once,
    // in its first unstalled cycle (which is also the exit cycle).
    assign Imem_Req      = (state == FETCH);
    assign RegWrite      = (state == WB) && !Stall;
    assign PC_En         = ((state == WB) || (state == BRANCH)) && !Stall;
    assign PCSrc         = (state == BRANCH);
    assign ALUSrc        = ir[OPC_LSB];
    assign ImmSel        = ir[OPC_MSB];
    assign Busy          = (state != IDLE) && (state != ERR);
    assign IR_Out        = ir;
    assign Timeout_Err   = err;
    assign Retired_Count = retired;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            ir      <= '0;
            retired <= '0;
            err     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) state <= FETCH;
                end
                FETCH: begin
                    if (Imem_Ack) begin
                        ir    <= Instr_In;
                        state <= DECODE;
                    end else if (wd_expired) begin
                        err   <= 1'b1;
                        state <= ERR;
                    end
                end
                DECODE: begin
                    if (!Stall) state <= ir[JUMP_BIT] ? BRANCH : EXEC;
                end
                EXEC: begin
                    if (!Stall) state <= WB;
                end
                WB, BRANCH: begin
                    if (!Stall) begin
                        retired <= retired + CNT_W'(1);
                        state   <= Stop ? IDLE : FETCH;
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: table-driven vectors plus directed sequences
// for reset abort, WB stall, fetch timeout and counter wrap.
module tb_multicycle_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start, Stop, Stall, Imem_Ack;
    logic [7:0]  Instr_In;
    logic        Imem_Req, PC_En, PCSrc, RegWrite, ALUSrc, ImmSel, Busy, Timeout_Err;
    logic [7:0]  IR_Out;
    logic [15:0] Retired_Count;

    logic        s2_start, s2_stop, s2_stall, s2_ack;
    logic [7:0]  s2_instr;
    logic        d2_req, d2_pcen, d2_pcsrc, d2_rw, d2_alusrc, d2_immsel, d2_busy, d2_err;
    logic [7:0]  d2_ir;
    logic [3:0]  d2_cnt;

    int checks   = 0;
    int failures = 0;
    int rw_pulses = 0;

    always #5 Clk = ~Clk;

    multicycle_sequencer #(.FETCH_TIMEOUT(16), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stop(Stop), .Stall(Stall),
        .Imem_Ack(Imem_Ack), .Instr_In(Instr_In), .Imem_Req(Imem_Req),
        .IR_Out(IR_Out), .PC_En(PC_En), .PCSrc(PCSrc), .RegWrite(RegWrite),
        .ALUSrc(ALUSrc), .ImmSel(ImmSel), .Busy(Busy),
        .Timeout_Err(Timeout_Err), .Retired_Count(Retired_Count)
    );

    multicycle_sequencer #(.FETCH_TIMEOUT(16), .CNT_W(4)) dut2 (
        .Clk(Clk), .Reset(Reset), .Start(s2_start), .Stop(s2_stop), .Stall(s2_stall),
        .Imem_Ack(s2_ack), .Instr_In(s2_instr), .Imem_Req(d2_req),
        .IR_Out(d2_ir), .PC_En(d2_pcen), .PCSrc(d2_pcsrc), .RegWrite(d2_rw),
        .ALUSrc(d2_alusrc), .ImmSel(d2_immsel), .Busy(d2_busy),
        .Timeout_Err(d2_err), .Retired_Count(d2_cnt)
    );

    always @(posedge Clk) if (RegWrite === 1'b1) rw_pulses++;

    typedef struct {
        logic        start, stop, stall, ack;
        logic [7:0]  instr;
        logic [6:0]  ctl; // req,pcen,pcsrc,rw,alusrc,immsel,busy
        logic [7:0]  ir;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[14];

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int p0;
        logic jmp;

        Reset = 1'b0; Start = 0; Stop = 0; Stall = 0; Imem_Ack = 0; Instr_In = 8'h00;
        s2_start = 0; s2_stop = 0; s2_stall = 0; s2_ack = 0; s2_instr = 8'h00;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 7'b0000000, 8'h00, 16'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h0A, 7'b1000001, 8'h00, 16'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 7'b0000001, 8'h0A, 16'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 7'b0000001, 8'h0A, 16'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 7'b0101001, 8'h0A, 16'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h85, 7'b1000001, 8'h0A, 16'd1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 7'b0000011, 8'h85, 16'd1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 7'b0110011, 8'h85, 16'd1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h4C, 7'b1000011, 8'h85, 16'd2};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 7'b0000101, 8'h4C, 16'd2};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 7'b0000101, 8'h4C, 16'd2};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 7'b0000101, 8'h4C, 16'd2};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 7'b0101101, 8'h4C, 16'd2};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 7'b0000100, 8'h4C, 16'd3};

        // Reset state
        step(); step();
        chk("rst_ctl", {Imem_Req, PC_En, PCSrc, RegWrite, ALUSrc, ImmSel, Busy, Timeout_Err}, 0);
        chk("rst_ir", IR_Out, 0);
        chk("rst_cnt", Retired_Count, 0);
        Reset = 1'b1;
        step();

        // Reset mid-EXEC aborts without strobes
        Start = 1; step(); Start = 0;
        Imem_Ack = 1; Instr_In = 8'h0A; step(); Imem_Ack = 0;
        step();
        p0 = rw_pulses;
        #2 Reset = 1'b0; #1;
        chk("abort_ctl", {Imem_Req, PC_En, PCSrc, RegWrite, ALUSrc, ImmSel, Busy}, 0);
        chk("abort_ir", IR_Out, 0);
        step();
        Reset = 1'b1; #1;
        chk("abort_busy", Busy, 0);
        step();
        chk("abort_idle", {Busy, Imem_Req}, 0);
        chk("abort_rw", rw_pulses - p0, 0);
        chk("abort_cnt", Retired_Count, 0);

        // Vector table: reg op, jump, stalled reg op with Stop
        for (int i = 0; i < 14; i++) begin
            Start = tbl[i].start; Stop = tbl[i].stop; Stall = tbl[i].stall;
            Imem_Ack = tbl[i].ack; Instr_In = tbl[i].instr;
            #1;
            chk($sformatf("vec%0d_ctl", i),
                {Imem_Req, PC_En, PCSrc, RegWrite, ALUSrc, ImmSel, Busy}, tbl[i].ctl);
            chk($sformatf("vec%0d_ir", i), IR_Out, tbl[i].ir);
            chk($sformatf("vec%0d_cnt", i), Retired_Count, tbl[i].cnt);
            step();
        end
        Start = 0; Stop = 0; Stall = 0; Imem_Ack = 0; Instr_In = 8'h00;

        // Stall 5 cycles in WB, one strobe after release
        Start = 1; step(); Start = 0;
        Imem_Ack = 1; Instr_In = 8'h0A; step(); Imem_Ack = 0;
        step(); step();
        Stall = 1; #1;
        p0 = rw_pulses;
        for (int i = 0; i < 5; i++) begin
            chk("stall_strobe", {RegWrite, PC_En}, 0);
            step();
        end
        Stall = 0; #1;
        chk("stall_release", {RegWrite, PC_En, PCSrc}, 3'b110);
        Stop = 1; step(); Stop = 0;
        chk("stall_pulses", rw_pulses - p0, 1);
        chk("stall_busy", Busy, 0);
        chk("stall_cnt", Retired_Count, 4);

        // Fetch watchdog
        Start = 1; step(); Start = 0;
        for (int i = 0; i < 16; i++) begin
            if (!(Imem_Req === 1'b1 && Timeout_Err === 1'b0)) begin
                chk($sformatf("wd_wait%0d", i), {Imem_Req, Timeout_Err}, 2'b10);
            end
            step();
        end
        chk("wd_err", {Timeout_Err, Busy, Imem_Req, PC_En, RegWrite}, 5'b10000);
        Start = 1; step(); Start = 0; step();
        chk("wd_sticky", {Timeout_Err, Busy, Imem_Req}, 3'b100);
        Reset = 0; step(); Reset = 1; #1;
        chk("wd_clear", {Timeout_Err, Busy}, 0);

        // Narrow counter wraps: 17 retires, Stop on the last
        s2_start = 1; step(); s2_start = 0;
        for (int n = 0; n < 17; n++) begin
            jmp = n[0];
            s2_ack = 1; s2_instr = jmp ? 8'h85 : 8'h0A;
            step(); s2_ack = 0;
            step();
            if (!jmp) step();
            s2_stop = (n == 16);
            #1;
            if (d2_pcen !== 1'b1) chk($sformatf("wrap_strobe%0d", n), d2_pcen, 1);
            step(); s2_stop = 0;
            if (n == 15) chk("wrap_zero", d2_cnt, 0);
        end
        chk("wrap_cnt", d2_cnt, 1);
        chk("wrap_idle", {d2_busy, d2_req}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
